uart_txrx_gen2: RTL and testbench
=================================

// Module: uart_txrx_gen2
// PURPOSE
// - Parametrised UART transceiver for IP validation links (host <-> FPGA).
// - Accepts multi-byte words, serialises them LSB byte first, transmits 8N1 (or 8E1 with the macro).
// - Buffers received bytes in an RX FIFO with ready/valid pop and error flags; loopback echoes RX to TX.
// - Self-contained: no vendor FIFO IP.
// PARAMETERS
// - OSR_DIV     16  sys_clk cycles per 1/16-bit oversample tick (bit period = 16*OSR_DIV cycles)
// - WORD_BYTES  4   bytes per tx_data word (1..8)
// - TX_DEPTH    16  TX byte FIFO depth, power of 2, >= WORD_BYTES
// - RX_DEPTH    16  RX byte FIFO depth, power of 2, >= 2
// PORTS
// - sys_clk       in   1             clock
// - sys_nrst      in   1             reset, asynchronous, active-low
// - lp_mode       in   1             1: RX bytes routed to TX FIFO (loopback)
// - tx_valid      in   1             word offered
// - tx_data       in   8*WORD_BYTES  word, byte 0 = [7:0] sent first
// - tx_ready      out  1             word accepted when tx_valid&tx_ready
// - tx_en         in   1             0: hold TX FIFO (frame in flight completes)
// - rx_valid      out  1             RX FIFO non-empty
// - rx_data       out  8             RX FIFO head (first-word fall-through)
// - rx_ready      in   1             pop when rx_valid&rx_ready
// - rx_clr        in   1             clears sticky error flags
// - rx_overrun    out  1             sticky: byte dropped, destination FIFO full
// - rx_frame_err  out  1             sticky: stop bit sampled 0
// - TX            out  1             serial out, idle high
// - RX            in   1             serial in (asynchronous)
// BEHAVIOUR
// - Reset: TX=1, tx_ready=0 for 1 cycle then tracks space, rx_valid=0, flags=0, FIFOs empty, FSMs idle.
// - Tick: counter 0..OSR_DIV-1, os_tick on wrap; tx bit boundary every 16 os_ticks.
// - tx_ready = ~lp_mode & ~packing & (TX free >= WORD_BYTES). On accept, word latched; one byte/cycle
//   pushed over next WORD_BYTES cycles (packing). lp_mode=1 forces tx_ready=0; in-progress packing completes.
// - TX FSM IDLE->START->DATA(8 bits, LSB first)->[PARITY]->STOP->IDLE, each state one bit period.
//   Pop only in IDLE when ~empty & tx_en; back-to-back frames without idle gap.
// - RX: 2-flop sync on RX; falling edge in IDLE -> START; start re-checked at os count 8, else abort to IDLE.
//   Data/stop sampled every 16 os_ticks from mid-start. Stop=0: frame_err set, byte still delivered.
// - RX delivery: lp_mode=0 -> RX FIFO, lp_mode=1 -> TX FIFO (arbitrated: loopback byte wins over packing, packing stalls 1 cycle).
// - FIFO rule: push accepted if count<DEPTH or pop same cycle; otherwise byte dropped, rx_overrun=1.
// - rx_clr and a same-cycle error event: set wins. Flags are never cleared by reset of data path alone.
// - lp_mode change mid-frame: byte goes to destination selected when stop bit is sampled.
// CONFIGURATION
// - UART_TXRX_PARITY_EN defined: even parity bit after data, both directions; output rx_parity_err (sticky,
//   cleared by rx_clr), errored byte still delivered. Undefined: 8N1, port absent, PARITY states absent.
// STRUCTURE
// - uart_pkg: tx_state_e, rx_state_e, OS_PER_BIT=16, DATA_BITS=8 constants.
// - Sub-module uart_sync_fifo #(WIDTH, DEPTH): FWFT, count output; instantiated for TX and RX.
// - Tick generator, packer, TX FSM, RX FSM inline.
// TESTING (OSR_DIV=4 -> bit = 64 cycles)
// - Reset release, idle -> TX=1 throughout, rx_valid=0, tx_ready=1 from cycle 2.
// - tx_data=32'hA5C3_0F81 -> TX bytes 81,0F,C3,A5 each 640 cycles, no gaps; tx_ready low until space returns.
// - tx_en=0 with 4 bytes queued -> TX stays 1; raise tx_en -> first start bit within 64 cycles.
// - Drive RX bytes 3C,F0 at correct rate -> rx_data 3C then F0, popped with rx_ready=1; no flags.
// - RX_DEPTH=4, 5 bytes, rx_ready=0 -> 4 bytes held, 5th dropped, rx_overrun=1; rx_clr -> 0.
// - Stop bit driven 0 on byte 55 -> rx_data=55, rx_frame_err=1; lp_mode=1 byte 7E -> TX echoes 7E, RX FIFO unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the uart_txrx_gen2 transceiver.
//   tx_state_e / rx_state_e : serial FSM state encodings
//   OS_PER_BIT              : oversample ticks per serial bit
//   DATA_BITS               : payload bits per frame
// Configuration macro: UART_TXRX_PARITY_EN adds the PARITY state to both FSMs.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OS_PER_BIT = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TXRX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_TXRX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock first-word-fall-through FIFO.
//   sys_clk, sys_nrst : clock, asynchronous active-low reset
//   push, push_data   : write request and data
//   push_ok           : write accepted this cycle (room, or a pop frees a slot)
//   pop               : remove head (ignored when empty)
//   head              : current head entry, valid whenever count != 0
//   count             : number of stored entries (0..DEPTH)
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_nrst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ok,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & (count != '0);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the processes are evaluated in.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; count and the
  // pointers define validity, and an unreset array maps onto plain RAM.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_txrx_gen2.sv
// -----------------------------------------------------------------------------
// uart_txrx_gen2
// UART transceiver: word-wide TX interface serialised LSB byte first into 8N1
// frames (8E1 with UART_TXRX_PARITY_EN), RX bytes buffered in a FWFT FIFO or
// echoed back to TX in loopback mode.
// Ports:
//   sys_clk, sys_nrst   clock, asynchronous active-low reset
//   lp_mode             1: received bytes go to the TX FIFO instead of RX FIFO
//   tx_valid/tx_ready   word handshake, tx_data byte 0 = [7:0] sent first
//   tx_en               0 holds the TX FIFO (frame in flight completes)
//   rx_valid/rx_ready   RX FIFO head handshake, rx_data = head
//   rx_clr              clears sticky error flags (a same-cycle event wins)
//   rx_overrun          sticky: received byte dropped, destination FIFO full
//   rx_frame_err        sticky: stop bit sampled low
//   rx_parity_err       sticky parity mismatch (only with UART_TXRX_PARITY_EN)
//   TX / RX             serial line out (idle high) / in (asynchronous)
// -----------------------------------------------------------------------------
module uart_txrx_gen2
  import uart_pkg::*;
#(
  parameter int OSR_DIV    = 16,
  parameter int WORD_BYTES = 4,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_nrst,
  input  logic                    lp_mode,
  input  logic                    tx_valid,
  input  logic [8*WORD_BYTES-1:0] tx_data,
  output logic                    tx_ready,
  input  logic                    tx_en,
  output logic                    rx_valid,
  output logic [7:0]              rx_data,
  input  logic                    rx_ready,
  input  logic                    rx_clr,
  output logic                    rx_overrun,
  output logic                    rx_frame_err,
`ifdef UART_TXRX_PARITY_EN
  output logic                    rx_parity_err,
`endif
  output logic                    TX,
  input  logic                    RX
);

  localparam int OSW = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int WBW = $clog2(WORD_BYTES + 1);

  // ---------------------------------------------------------------------------
  // Oversample tick and post-reset ready gate
  // ---------------------------------------------------------------------------
  logic [OSW-1:0] os_cnt;
  logic           os_tick;
  logic           ready_en;

  assign os_tick = (os_cnt == OSW'(OSR_DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      os_cnt   <= '0;
      ready_en <= 1'b0;
    end else begin
      os_cnt   <= os_tick ? '0 : os_cnt + 1'b1;
      ready_en <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  logic                 tx_push, tx_push_ok, tx_pop;
  logic [DATA_BITS-1:0] tx_push_data, tx_head;
  logic [TCW-1:0]       tx_count;
  logic                 rx_push, rx_push_ok;
  logic [RCW-1:0]       rx_count;
  logic [DATA_BITS-1:0] rx_shreg;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .sys_clk   (sys_clk),
    .sys_nrst  (sys_nrst),
    .push      (tx_push),
    .push_data (tx_push_data),
    .push_ok   (tx_push_ok),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .sys_clk   (sys_clk),
    .sys_nrst  (sys_nrst),
    .push      (rx_push),
    .push_data (rx_shreg),
    .push_ok   (rx_push_ok),
    .pop       (rx_ready),
    .head      (rx_data),
    .count     (rx_count)
  );

  assign rx_valid = (rx_count != '0);

  // ---------------------------------------------------------------------------
  // Word packer: one byte per cycle into the TX FIFO, LSB byte first
  // ---------------------------------------------------------------------------
  logic [8*WORD_BYTES-1:0] pack_word;
  logic [WBW-1:0]          pack_left;
  logic                    packing, pack_push, tx_accept, lb_push;

  assign packing   = (pack_left != '0);
  assign tx_ready  = ready_en & ~lp_mode & ~packing
                   & (tx_count <= TCW'(TX_DEPTH - WORD_BYTES));
  assign tx_accept = tx_valid & tx_ready;
  // A loopback byte owns the FIFO write port; the packer retries next cycle.
  assign pack_push    = packing & ~lb_push;
  assign tx_push      = lb_push | pack_push;
  assign tx_push_data = lb_push ? rx_shreg : pack_word[7:0];

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      pack_word <= '0;
      pack_left <= '0;
    end else if (tx_accept) begin
      pack_word <= tx_data;
      pack_left <= WBW'(WORD_BYTES);
    end else if (pack_push && tx_push_ok) begin
      pack_word <= pack_word >> 8;
      pack_left <= pack_left - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_e            tx_state, tx_state_nx;
  logic [3:0]           tx_os;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_bit_end, tx_start_ok, serial_d;
`ifdef UART_TXRX_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_bit_end  = os_tick & (tx_os == 4'(OS_PER_BIT - 1));
  assign tx_start_ok = (tx_count != '0) & tx_en;

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) tx_state <= TX_IDLE;
    else           tx_state <= tx_state_nx;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_state_nx = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (os_tick && tx_start_ok) tx_state_nx = TX_START;
      TX_START: if (tx_bit_end) tx_state_nx = TX_DATA;
`ifdef UART_TXRX_PARITY_EN
      TX_DATA:   if (tx_bit_end && tx_bit == 3'(DATA_BITS - 1)) tx_state_nx = TX_PARITY;
      TX_PARITY: if (tx_bit_end) tx_state_nx = TX_STOP;
`else
      TX_DATA:   if (tx_bit_end && tx_bit == 3'(DATA_BITS - 1)) tx_state_nx = TX_STOP;
`endif
      // Chaining straight into the next start bit keeps frames gap-free.
      TX_STOP:  if (tx_bit_end) tx_state_nx = tx_start_ok ? TX_START : TX_IDLE;
      default:  tx_state_nx = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop   = (tx_state_nx == TX_START) && (tx_state != TX_START);
    serial_d = 1'b1;
    unique case (tx_state)
      TX_START:  serial_d = 1'b0;
      TX_DATA:   serial_d = tx_shreg[0];
`ifdef UART_TXRX_PARITY_EN
      TX_PARITY: serial_d = tx_par;
`endif
      default:   serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      TX       <= 1'b1;
`ifdef UART_TXRX_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      TX <= serial_d;
      // Bit timing restarts from the tick that leaves IDLE.
      if (tx_state == TX_IDLE) tx_os <= '0;
      else if (os_tick)        tx_os <= tx_bit_end ? '0 : tx_os + 1'b1;
      if (tx_pop) begin
        tx_shreg <= tx_head;
        tx_bit   <= '0;
`ifdef UART_TXRX_PARITY_EN
        tx_par   <= even_parity(tx_head);
`endif
      end else if (tx_state == TX_DATA && tx_bit_end) begin
        tx_shreg <= tx_shreg >> 1;
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX synchroniser and FSM
  // ---------------------------------------------------------------------------
  rx_state_e  rx_state, rx_state_nx;
  logic       rx_s1, rx_s2, rx_s3;
  logic [3:0] rx_os;
  logic [2:0] rx_bit;
  logic       rx_fall, rx_sample, rx_deliver, overrun_ev, frame_ev;
`ifdef UART_TXRX_PARITY_EN
  logic       parity_ev;
`endif

  // rx_s1/rx_s2 resolve metastability; rx_s3 only serves edge detection.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;
  // Half a bit into the start bit, then one full bit per later sample.
  assign rx_sample = os_tick & (rx_os == ((rx_state == RX_START) ? 4'(OS_PER_BIT/2 - 1)
                                                                  : 4'(OS_PER_BIT - 1)));

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) rx_state <= RX_IDLE;
    else           rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nx = RX_START;
      // A start bit that is high again at mid-bit was a glitch.
      RX_START: if (rx_sample) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
`ifdef UART_TXRX_PARITY_EN
      RX_DATA:   if (rx_sample && rx_bit == 3'(DATA_BITS - 1)) rx_state_nx = RX_PARITY;
      RX_PARITY: if (rx_sample) rx_state_nx = RX_STOP;
`else
      RX_DATA:   if (rx_sample && rx_bit == 3'(DATA_BITS - 1)) rx_state_nx = RX_STOP;
`endif
      RX_STOP:  if (rx_sample) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_deliver = (rx_state == RX_STOP) & rx_sample;
    frame_ev   = rx_deliver & ~rx_s2;
    // Destination is chosen by lp_mode at the stop-bit sample.
    lb_push    = rx_deliver & lp_mode;
    rx_push    = rx_deliver & ~lp_mode;
    overrun_ev = (lb_push & ~tx_push_ok) | (rx_push & ~rx_push_ok);
`ifdef UART_TXRX_PARITY_EN
    parity_ev  = (rx_state == RX_PARITY) & rx_sample & (rx_s2 != even_parity(rx_shreg));
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_sample) rx_os <= '0;
      else if (os_tick)                     rx_os <= rx_os + 1'b1;
      if (rx_state == RX_START && rx_sample) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_sample) begin
        rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a same-cycle event beats rx_clr
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rx_overrun    <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_TXRX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      if (overrun_ev)  rx_overrun   <= 1'b1;
      else if (rx_clr) rx_overrun   <= 1'b0;
      if (frame_ev)    rx_frame_err <= 1'b1;
      else if (rx_clr) rx_frame_err <= 1'b0;
`ifdef UART_TXRX_PARITY_EN
      if (parity_ev)   rx_parity_err <= 1'b1;
      else if (rx_clr) rx_parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_txrx_gen2.sv
// -----------------------------------------------------------------------------
// tb_uart_txrx_gen2
// Directed bench for uart_txrx_gen2 with OSR_DIV=4 (64 cycles per bit),
// WORD_BYTES=4, TX_DEPTH=16, RX_DEPTH=4. A line monitor decodes TX frames into
// queues; the main sequence drives RX frames and compares against literals.
// Honours UART_TXRX_PARITY_EN for frame length and the parity port.
// -----------------------------------------------------------------------------
module tb_uart_txrx_gen2;

  localparam int BIT  = 64;
`ifdef UART_TXRX_PARITY_EN
  localparam int FRAME_CYC = 11 * BIT;
`else
  localparam int FRAME_CYC = 10 * BIT;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_nrst;
  logic        lp_mode, tx_valid, tx_ready, tx_en;
  logic [31:0] tx_data;
  logic        rx_valid, rx_ready, rx_clr, rx_overrun, rx_frame_err;
  logic [7:0]  rx_data;
  logic        TX, RX;
`ifdef UART_TXRX_PARITY_EN
  logic        rx_parity_err;
`endif

  uart_txrx_gen2 #(.OSR_DIV(4), .WORD_BYTES(4), .TX_DEPTH(16), .RX_DEPTH(4)) dut (
    .sys_clk      (sys_clk),
    .sys_nrst     (sys_nrst),
    .lp_mode      (lp_mode),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_en        (tx_en),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_clr       (rx_clr),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
`ifdef UART_TXRX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .TX           (TX),
    .RX           (RX)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- TX line monitor ----------------
  logic [7:0] mon_byte [$];
  logic       mon_ok   [$];
  int         mon_t    [$];
  logic [7:0] m_b;
  logic       m_ok;
  int         m_t;

  always begin
    @(negedge sys_clk);
    if (sys_nrst === 1'b1 && TX === 1'b0) begin
      m_t  = cyc;
      m_ok = 1'b1;
      repeat (BIT/2) @(negedge sys_clk);
      if (TX !== 1'b0) m_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge sys_clk);
        m_b[i] = TX;
      end
`ifdef UART_TXRX_PARITY_EN
      repeat (BIT) @(negedge sys_clk);
      if (TX !== ^m_b) m_ok = 1'b0;
`endif
      repeat (BIT) @(negedge sys_clk);
      if (TX !== 1'b1) m_ok = 1'b0;
      mon_byte.push_back(m_b);
      mon_ok.push_back(m_ok);
      mon_t.push_back(m_t);
    end
  end

  function automatic logic [31:0] byte_at(input int i);
    return (i < mon_byte.size()) ? {24'd0, mon_byte[i]} : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] ok_at(input int i);
    return (i < mon_ok.size()) ? {31'd0, mon_ok[i]} : 32'hxxxx_xxxx;
  endfunction

  function automatic int t_at(input int i);
    return (i < mon_t.size()) ? mon_t[i] : -100000;
  endfunction

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (mon_byte.size() < n && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    check(tag, 32'(mon_byte.size() >= n), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (BIT) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BIT) @(negedge sys_clk);
    end
`ifdef UART_TXRX_PARITY_EN
    RX = ^b;
    repeat (BIT) @(negedge sys_clk);
`endif
    RX = stop_bit;
    repeat (BIT) @(negedge sys_clk);
    RX = 1'b1;
    repeat (BIT) @(negedge sys_clk);
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    @(negedge sys_clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    rx_clr = 1'b1;
    @(negedge sys_clk);
    rx_clr = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int   nb, t0;
  logic saw_low;

  initial begin
    sys_nrst = 1'b0;
    lp_mode  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 32'd0;
    tx_en    = 1'b1;
    rx_ready = 1'b0;
    rx_clr   = 1'b0;
    RX       = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Reset state
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    check("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);

    sys_nrst = 1'b1;
    #1;
    check("ready_cycle1", {31'd0, tx_ready}, 32'd0);
    @(negedge sys_clk);
    check("ready_cycle2", {31'd0, tx_ready}, 32'd1);
    saw_low = 1'b0;
    repeat (200) begin
      @(negedge sys_clk);
      if (TX !== 1'b1) saw_low = 1'b1;
    end
    check("idle_tx_high", {31'd0, saw_low}, 32'd0);
    check("idle_rx_valid", {31'd0, rx_valid}, 32'd0);

    // Word transmit: bytes 81,0F,C3,A5 back to back
    nb = mon_byte.size();
    tx_data  = 32'hA5C3_0F81;
    tx_valid = 1'b1;
    check("word_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge sys_clk);
    tx_valid = 1'b0;
    check("ready_packing", {31'd0, tx_ready}, 32'd0);
    repeat (6) @(negedge sys_clk);
    check("ready_back", {31'd0, tx_ready}, 32'd1);
    wait_frames(nb + 4, 4 * FRAME_CYC + 200, "word_frames");
    check("tx_b0", byte_at(nb),     32'h81);
    check("tx_b1", byte_at(nb + 1), 32'h0F);
    check("tx_b2", byte_at(nb + 2), 32'hC3);
    check("tx_b3", byte_at(nb + 3), 32'hA5);
    check("tx_f0", ok_at(nb),     32'd1);
    check("tx_f3", ok_at(nb + 3), 32'd1);
    check("gap01", 32'(t_at(nb + 1) - t_at(nb)),     32'(FRAME_CYC));
    check("gap12", 32'(t_at(nb + 2) - t_at(nb + 1)), 32'(FRAME_CYC));
    check("gap23", 32'(t_at(nb + 3) - t_at(nb + 2)), 32'(FRAME_CYC));

    // tx_en hold: 4 bytes queued, line stays idle
    tx_en = 1'b0;
    nb = mon_byte.size();
    tx_data  = 32'h1122_3344;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    repeat (40) @(negedge sys_clk);   // let the previous stop bit finish
    saw_low = 1'b0;
    repeat (300) begin
      @(negedge sys_clk);
      if (TX !== 1'b1) saw_low = 1'b1;
    end
    check("hold_tx_high", {31'd0, saw_low}, 32'd0);
    check("hold_no_frame", 32'(mon_byte.size()), 32'(nb));
    tx_en = 1'b1;
    t0 = cyc;
    wait_frames(nb + 4, 4 * FRAME_CYC + 200, "en_frames");
    check("en_latency", 32'((t_at(nb) - t0) <= BIT), 32'd1);
    check("en_b0", byte_at(nb),     32'h44);
    check("en_b1", byte_at(nb + 1), 32'h33);
    check("en_b2", byte_at(nb + 2), 32'h22);
    check("en_b3", byte_at(nb + 3), 32'h11);
    repeat (BIT) @(negedge sys_clk);

    // RX bytes 3C, F0
    send_rx(8'h3C, 1'b1);
    send_rx(8'hF0, 1'b1);
    check("rx_valid_1", {31'd0, rx_valid}, 32'd1);
    check("rx_3c", {24'd0, rx_data}, 32'h3C);
    pop_rx();
    check("rx_f0", {24'd0, rx_data}, 32'hF0);
    pop_rx();
    check("rx_empty_1", {31'd0, rx_valid}, 32'd0);
    check("rx_no_ovr", {31'd0, rx_overrun}, 32'd0);
    check("rx_no_ferr", {31'd0, rx_frame_err}, 32'd0);

    // Overrun: 4 fill the FIFO, the 5th is dropped
    send_rx(8'h01, 1'b1);
    send_rx(8'h02, 1'b1);
    send_rx(8'h03, 1'b1);
    send_rx(8'h04, 1'b1);
    check("full_no_ovr", {31'd0, rx_overrun}, 32'd0);
    send_rx(8'h05, 1'b1);
    check("ovr_set", {31'd0, rx_overrun}, 32'd1);
    check("ovr_h1", {24'd0, rx_data}, 32'h01);
    pop_rx();
    check("ovr_h2", {24'd0, rx_data}, 32'h02);
    pop_rx();
    check("ovr_h3", {24'd0, rx_data}, 32'h03);
    pop_rx();
    check("ovr_h4", {24'd0, rx_data}, 32'h04);
    pop_rx();
    check("ovr_empty", {31'd0, rx_valid}, 32'd0);
    check("ovr_held", {31'd0, rx_overrun}, 32'd1);
    pulse_clr();
    check("ovr_clr", {31'd0, rx_overrun}, 32'd0);

    // Frame error: stop bit low, byte still delivered
    send_rx(8'h55, 1'b0);
    check("ferr_valid", {31'd0, rx_valid}, 32'd1);
    check("ferr_data", {24'd0, rx_data}, 32'h55);
    check("ferr_set", {31'd0, rx_frame_err}, 32'd1);
    pop_rx();
    pulse_clr();
    check("ferr_clr", {31'd0, rx_frame_err}, 32'd0);

    // Loopback: RX byte echoed on TX, RX FIFO untouched
    lp_mode = 1'b1;
    @(negedge sys_clk);
    check("lp_ready_low", {31'd0, tx_ready}, 32'd0);
    nb = mon_byte.size();
    send_rx(8'h7E, 1'b1);
    wait_frames(nb + 1, 2 * FRAME_CYC, "lp_frame");
    check("lp_echo", byte_at(nb), 32'h7E);
    check("lp_echo_ok", ok_at(nb), 32'd1);
    check("lp_rx_empty", {31'd0, rx_valid}, 32'd0);
    lp_mode = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
